axilite_mmio_responder: RTL and testbench

- AXI4-Lite slave (responder) that terminates the core's MMIO master port on the uncore clock domain.
- Provides a small memory-mapped register window:
  - read-only ID register
  - loadable free-running cycle counter
  - NREGS scratch registers
- One outstanding read plus one outstanding write.
- Bench target and bring-up endpoint for the core's AXI-Lite MMIO initiator.

---
 rtl/axilite_mmio_responder.sv | 200 ++++++++++++++++++++
 tb/tb_axilite_mmio_responder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axilite_mmio_responder.sv
// AXI4-Lite MMIO responder: ID, loadable cycle counter, NREGS scratch regs.
// Optional AXILITE_MMIO_ERR_EN: SLVERR on out-of-range access and ID writes.
module axilite_mmio_responder #(
  parameter int          NREGS      = 4,
  parameter logic [31:0] ID_VALUE   = 32'h5052_4443,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  uncoreclk,
  input  logic                  uncore_rstn,
  input  logic [ADDR_WIDTH-1:0] S_AXILITE_MMIO_awaddr,
  input  logic                  S_AXILITE_MMIO_awvalid,
  output logic                  S_AXILITE_MMIO_awready,
  input  logic [31:0]           S_AXILITE_MMIO_wdata,
  input  logic [3:0]            S_AXILITE_MMIO_wstrb,
  input  logic                  S_AXILITE_MMIO_wvalid,
  output logic                  S_AXILITE_MMIO_wready,
  output logic [1:0]            S_AXILITE_MMIO_bresp,
  output logic                  S_AXILITE_MMIO_bvalid,
  input  logic                  S_AXILITE_MMIO_bready,
  input  logic [ADDR_WIDTH-1:0] S_AXILITE_MMIO_araddr,
  input  logic                  S_AXILITE_MMIO_arvalid,
  output logic                  S_AXILITE_MMIO_arready,
  output logic [31:0]           S_AXILITE_MMIO_rdata,
  output logic [1:0]            S_AXILITE_MMIO_rresp,
  output logic                  S_AXILITE_MMIO_rvalid,
  input  logic                  S_AXILITE_MMIO_rready
);

`ifdef AXILITE_MMIO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;
  localparam logic [10:0] TOP    = 11'(NREGS + 2);

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t     wstate;
  rstate_t     rstate;
  logic [31:0] cycle;
  logic [31:0] scratch [NREGS];
  logic        aw_have;
  logic        w_have;
  logic [9:0]  aw_idx;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  logic [9:0]  rd_idx;
  logic [31:0] rd_val;
  logic        rd_err;
  logic        commit;
  logic        cyc_load;
  logic        wr_err;
  logic        unused_addr;

  assign unused_addr = ^{S_AXILITE_MMIO_awaddr, S_AXILITE_MMIO_araddr};

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] data,
    input logic [3:0]  strb
  );
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) m[8*b +: 8] = data[8*b +: 8];
    end
    return m;
  endfunction

  function automatic logic in_scratch(input logic [9:0] idx);
    return (idx >= 10'd2) && ({1'b0, idx} < TOP);
  endfunction

  assign rd_idx = S_AXILITE_MMIO_araddr[11:2];

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    unique case (1'b1)
      rd_idx == 10'd0: rd_val = ID_VALUE;
      rd_idx == 10'd1: rd_val = cycle;
      in_scratch(rd_idx): begin
        for (int i = 0; i < NREGS; i++) begin
          if (rd_idx == 10'(i + 2)) rd_val = scratch[i];
        end
      end
      default: rd_err = 1'b1;
    endcase
  end

  assign commit   = (wstate == W_IDLE) && aw_have && w_have;
  assign cyc_load = commit && (aw_idx == 10'd1) && (|w_strb);
  assign wr_err   = (aw_idx == 10'd0) ||
                    ((aw_idx != 10'd1) && !in_scratch(aw_idx));

  // A load replaces the increment for that cycle.
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      cycle <= '0;
    end else if (cyc_load) begin
      cycle <= merge(cycle, w_data, w_strb);
    end else begin
      cycle <= cycle + 32'd1;
    end
  end

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      for (int i = 0; i < NREGS; i++) scratch[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NREGS; i++) begin
        if (aw_idx == 10'(i + 2))
          scratch[i] <= merge(scratch[i], w_data, w_strb);
      end
    end
  end

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      wstate                 <= W_IDLE;
      S_AXILITE_MMIO_awready <= 1'b1;
      S_AXILITE_MMIO_wready  <= 1'b1;
      S_AXILITE_MMIO_bvalid  <= 1'b0;
      S_AXILITE_MMIO_bresp   <= OKAY;
      aw_have                <= 1'b0;
      w_have                 <= 1'b0;
      aw_idx                 <= '0;
      w_data                 <= '0;
      w_strb                 <= '0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (S_AXILITE_MMIO_awready && S_AXILITE_MMIO_awvalid) begin
            aw_have                <= 1'b1;
            aw_idx                 <= S_AXILITE_MMIO_awaddr[11:2];
            S_AXILITE_MMIO_awready <= 1'b0;
          end
          if (S_AXILITE_MMIO_wready && S_AXILITE_MMIO_wvalid) begin
            w_have                <= 1'b1;
            w_data                <= S_AXILITE_MMIO_wdata;
            w_strb                <= S_AXILITE_MMIO_wstrb;
            S_AXILITE_MMIO_wready <= 1'b0;
          end
          if (commit) begin
            wstate                <= W_RESP;
            aw_have               <= 1'b0;
            w_have                <= 1'b0;
            S_AXILITE_MMIO_bvalid <= 1'b1;
            S_AXILITE_MMIO_bresp  <= (ERR_EN && wr_err) ? SLVERR : OKAY;
          end
        end
        W_RESP: begin
          if (S_AXILITE_MMIO_bready) begin
            wstate                 <= W_IDLE;
            S_AXILITE_MMIO_bvalid  <= 1'b0;
            S_AXILITE_MMIO_awready <= 1'b1;
            S_AXILITE_MMIO_wready  <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      rstate                 <= R_IDLE;
      S_AXILITE_MMIO_arready <= 1'b1;
      S_AXILITE_MMIO_rvalid  <= 1'b0;
      S_AXILITE_MMIO_rdata   <= '0;
      S_AXILITE_MMIO_rresp   <= OKAY;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (S_AXILITE_MMIO_arvalid) begin
            rstate                 <= R_DATA;
            S_AXILITE_MMIO_arready <= 1'b0;
            S_AXILITE_MMIO_rvalid  <= 1'b1;
            S_AXILITE_MMIO_rdata   <= rd_val;
            S_AXILITE_MMIO_rresp   <= (ERR_EN && rd_err) ? SLVERR : OKAY;
          end
        end
        R_DATA: begin
          if (S_AXILITE_MMIO_rready) begin
            rstate                 <= R_IDLE;
            S_AXILITE_MMIO_rvalid  <= 1'b0;
            S_AXILITE_MMIO_arready <= 1'b1;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_mmio_responder.sv
// Randomized bench for axilite_mmio_responder against a transaction-level model.
// Honors AXILITE_MMIO_ERR_EN for expected response codes.
module tb_axilite_mmio_responder;

  localparam int          NREGS = 4;
  localparam logic [31:0] ID    = 32'h5052_4443;
`ifdef AXILITE_MMIO_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axilite_mmio_responder #(.NREGS(NREGS)) dut (
    .uncoreclk(clk), .uncore_rstn(rst_n),
    .S_AXILITE_MMIO_awaddr(awaddr), .S_AXILITE_MMIO_awvalid(awvalid),
    .S_AXILITE_MMIO_awready(awready), .S_AXILITE_MMIO_wdata(wdata),
    .S_AXILITE_MMIO_wstrb(wstrb), .S_AXILITE_MMIO_wvalid(wvalid),
    .S_AXILITE_MMIO_wready(wready), .S_AXILITE_MMIO_bresp(bresp),
    .S_AXILITE_MMIO_bvalid(bvalid), .S_AXILITE_MMIO_bready(bready),
    .S_AXILITE_MMIO_araddr(araddr), .S_AXILITE_MMIO_arvalid(arvalid),
    .S_AXILITE_MMIO_arready(arready), .S_AXILITE_MMIO_rdata(rdata),
    .S_AXILITE_MMIO_rresp(rresp), .S_AXILITE_MMIO_rvalid(rvalid),
    .S_AXILITE_MMIO_rready(rready)
  );

  int     compared = 0;
  int     mismatched = 0;
  longint edges = 0;

  always @(posedge clk) edges <= edges + 1;

  // Model: register contents plus outstanding-transaction bookkeeping.
  logic [31:0] m_scr [NREGS];
  logic [31:0] m_base;
  longint      m_l;
  bit          m_awhave, m_whave, m_bpend, m_rpend;
  logic [9:0]  m_awidx;
  logic [31:0] m_wd, m_rdata;
  logic [3:0]  m_ws;
  logic [1:0]  m_bresp, m_rresp;
  bit          hs_aw, hs_w, hs_ar, hs_b, hs_r;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: handshake did not happen within bound at %0t",
             nm, $time);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, d,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = o;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = d[8*b +: 8];
    return m;
  endfunction

  // Counter value visible just before the next rising edge.
  function automatic logic [31:0] m_cyc();
    return m_base + 32'(edges - m_l);
  endfunction

  function automatic logic [32:0] mread(input logic [9:0] idx);
    int k;
    k = int'(idx);
    if (k == 0) return {1'b0, ID};
    if (k == 1) return {1'b0, m_cyc()};
    if (k >= 2 && k < NREGS + 2) return {1'b0, m_scr[k-2]};
    return {1'b1, 32'h0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_scr[i] = '0;
    m_base = '0;
    m_l = edges;
    m_awhave = 0; m_whave = 0; m_bpend = 0; m_rpend = 0;
  endtask

  // Advance the model over the next edge, then compare at the falling edge.
  task automatic tick();
    logic [32:0] rv;
    logic [31:0] cnow;
    int k;
    cnow  = m_cyc();
    hs_aw = !m_awhave && !m_bpend && awvalid;
    hs_w  = !m_whave && !m_bpend && wvalid;
    hs_ar = !m_rpend && arvalid;
    hs_b  = m_bpend && bready;
    hs_r  = m_rpend && rready;
    if (hs_r) m_rpend = 0;
    if (hs_ar) begin
      rv = mread(araddr[11:2]);
      m_rpend = 1;
      m_rdata = rv[31:0];
      m_rresp = (ERR && rv[32]) ? 2'b10 : 2'b00;
    end
    if (hs_b) begin
      m_bpend = 0;
    end else if (m_awhave && m_whave) begin
      k = int'(m_awidx);
      if (k == 1 && m_ws != 0) begin
        m_base = merge(cnow, m_wd, m_ws);
        m_l = edges + 1;
      end
      if (k >= 2 && k < NREGS + 2) m_scr[k-2] = merge(m_scr[k-2], m_wd, m_ws);
      m_bresp = (ERR && (k == 0 || k >= NREGS + 2)) ? 2'b10 : 2'b00;
      m_bpend = 1; m_awhave = 0; m_whave = 0;
    end
    if (hs_aw) begin m_awhave = 1; m_awidx = awaddr[11:2]; end
    if (hs_w) begin m_whave = 1; m_wd = wdata; m_ws = wstrb; end
    @(posedge clk);
    @(negedge clk);
    chk("awready", awready, !m_awhave && !m_bpend);
    chk("wready", wready, !m_whave && !m_bpend);
    chk("arready", arready, !m_rpend);
    chk("bvalid", bvalid, m_bpend);
    chk("rvalid", rvalid, m_rpend);
    if (m_bpend) chk("bresp", bresp, m_bresp);
    if (m_rpend) begin
      chk("rdata", rdata, m_rdata);
      chk("rresp", rresp, m_rresp);
    end
  endtask

  task automatic wr(input logic [31:0] a, d, input logic [3:0] s,
                    input int wlead, input int hold, output logic [1:0] br);
    int g;
    bready = 0; wvalid = 1; wdata = d; wstrb = s;
    for (int i = 0; i < wlead; i++) begin
      tick();
      if (hs_w) wvalid = 0;
      if (i == 0) chk("wready_drop", wready, 0);
    end
    awvalid = 1; awaddr = a;
    g = 0;
    while ((awvalid || wvalid) && g < 20) begin
      tick();
      if (hs_aw) awvalid = 0;
      if (hs_w) wvalid = 0;
      g++;
    end
    if (awvalid || wvalid) timeout("wr_addr_data");
    awvalid = 0; wvalid = 0;
    chk("bvalid_early", bvalid, 0);
    tick();
    chk("bvalid_lat", bvalid, 1);
    br = bresp;
    repeat (hold) tick();
    bready = 1;
    tick();
    bready = 0;
  endtask

  task automatic rd(input logic [31:0] a, input int hold,
                    output logic [31:0] d, output logic [1:0] r);
    int g;
    rready = 0; arvalid = 1; araddr = a;
    g = 0;
    do begin tick(); g++; end while (!hs_ar && g < 20);
    arvalid = 0;
    if (!hs_ar) timeout("rd_addr");
    chk("rvalid_lat", rvalid, 1);
    d = rdata; r = rresp;
    repeat (hold) tick();
    rready = 1;
    tick();
    rready = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    logic [9:0]  i;
    a = $urandom;
    case ($urandom_range(0, 7))
      6:       i = 10'h3FF;
      7:       i = 10'($urandom);
      default: i = 10'($urandom_range(0, NREGS + 1));
    endcase
    a[11:2] = i;
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r, br;
    int g;
    rst_n = 0;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1;
    model_reset();

    rd(32'h000, 0, d, r);
    chk("id_data", d, 32'h5052_4443);
    chk("id_resp", r, 2'b00);

    wr(32'h008, 32'hDEAD_BEEF, 4'hF, 3, 0, br);
    rd(32'h008, 0, d, r);
    chk("scr0_full", d, 32'hDEAD_BEEF);
    wr(32'h008, 32'h0000_5500, 4'b0010, 3, 0, br);
    rd(32'h008, 0, d, r);
    chk("scr0_byte", d, 32'hDEAD_55EF);

    wr(32'h010, 32'h0A0B_0C0D, 4'hF, 0, 5, br);
    rd(32'h010, 5, d, r);
    chk("hold_data", d, 32'h0A0B_0C0D);

    wr(32'h004, 32'hFFFF_FFFE, 4'hF, 0, 0, br);
    tick();
    rd(32'h004, 0, d, r);
    chk("cycle_wrap", d, 32'h0000_0000);

    wr(32'h00C, 32'h1, 4'hF, 0, 0, br);
    wdata = 32'h2; wstrb = 4'hF; awaddr = 32'h00C;
    wvalid = 1; awvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    arvalid = 1; araddr = 32'h00C;
    tick();
    arvalid = 0;
    chk("same_cyc_old", rdata, 32'h1);
    chk("same_cyc_bvalid", bvalid, 1);
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    rd(32'h00C, 0, d, r);
    chk("same_cyc_new", d, 32'h2);

    wr(32'hFFC, 32'h1234_5678, 4'hF, 0, 0, br);
    chk("oor_bresp", br, ERR ? 2'b10 : 2'b00);
    rd(32'hFFC, 0, d, r);
    chk("oor_rdata", d, 0);
    chk("oor_rresp", r, ERR ? 2'b10 : 2'b00);
    wr(32'h000, 32'h0, 4'hF, 1, 0, br);
    chk("id_wr_bresp", br, ERR ? 2'b10 : 2'b00);
    rd(32'h000, 0, d, r);
    chk("id_after_wr", d, ID);

    repeat (2000) begin
      if (!awvalid && $urandom_range(0, 2) == 0) begin
        awvalid = 1; awaddr = rand_addr();
      end
      if (!wvalid && $urandom_range(0, 2) == 0) begin
        wvalid = 1; wdata = $urandom; wstrb = 4'($urandom);
      end
      if (!arvalid && $urandom_range(0, 2) == 0) begin
        arvalid = 1; araddr = rand_addr();
      end
      bready = 1'($urandom); rready = 1'($urandom);
      tick();
      if (hs_aw) awvalid = 0;
      if (hs_w) wvalid = 0;
      if (hs_ar) arvalid = 0;
    end
    bready = 1; rready = 1;
    g = 0;
    while ((awvalid || wvalid || arvalid || m_bpend || m_rpend ||
            m_awhave || m_whave) && g < 50) begin
      if (m_awhave && !m_whave && !wvalid) begin
        wvalid = 1; wdata = $urandom; wstrb = 4'hF;
      end
      if (m_whave && !m_awhave && !awvalid) begin
        awvalid = 1; awaddr = rand_addr();
      end
      tick();
      if (hs_aw) awvalid = 0;
      if (hs_w) wvalid = 0;
      if (hs_ar) arvalid = 0;
      g++;
    end
    if (g >= 50) timeout("drain");
    bready = 0; rready = 0;

    awaddr = 32'h014; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    #2 rst_n = 0;
    #1;
    chk("midrst_bvalid", bvalid, 0);
    chk("midrst_awready", awready, 1);
    chk("midrst_wready", wready, 1);
    chk("midrst_arready", arready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    rd(32'h014, 0, d, r);
    chk("midrst_scr3", d, 0);
    rd(32'h004, 0, d, r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
